addsub_result_checker: RTL and testbench
========================================

// Module: addsub_result_checker
// PURPOSE
// - Consumer end of the add/sub datapath. Watches the 32-bit stimulus word driven into addsub_top and
//   the registered result coming back, recomputes the expected result in a delay-matched pipeline,
//   and counts and captures mismatches.
// - Sits beside addsub_top in the self-checking top and drives the pass/fail status for the board run.
// PARAMETERS
// - WIDTH    32  stimulus/result width; the operand packing below requires WIDTH == 32
// - LATENCY  2   cycles from data_in to data_out in addsub_top: addsub register + output register
// - CNT_W    16  width of the vector counter, error counter and index fields
// PORTS
// - clk            in   1       rising-edge clock, shared with addsub_top
// - rst            in   1       synchronous active-high reset
// - start          in   1       pulse; arms a run of num_vectors checks
// - num_vectors    in   CNT_W   number of results to check in the run; sampled on start
// - stim           in   WIDTH   word presented to addsub_top data_in in the same cycle
// - obs            in   WIDTH   addsub_top data_out
// - busy           out  1       run in progress
// - done           out  1       one-cycle pulse at end of run
// - pass           out  1       set at done when err_count == 0; held until next start
// - err_count      out  CNT_W   mismatches in the current run; saturates at all-ones
// - first_err_idx  out  CNT_W   vector index of the first mismatch
// - first_err_exp  out  WIDTH   expected value at the first mismatch
// - first_err_obs  out  WIDTH   observed value at the first mismatch
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; pipeline valid bits cleared.
// - Expected-value model, from stim:
//   - a = stim[15:0], b = stim[31:16], op = stim[0] (shares the LSB of a).
//   - op=1: exp = {16'b0, a} + {16'b0, b}, computed in 32 bits, so the carry lands in bit 16.
//   - op=0: exp = {16'b0, a} - {16'b0, b}, 32-bit modular; e.g. a<b gives 0xFFFF_xxxx.
// - Pipeline:
//   - exp and a valid bit travel through a LATENCY-deep shift register.
//   - Compare obs against the stage-LATENCY value only when that stage's valid bit is 1.
// - State IDLE:
//   - On start with num_vectors != 0: latch the count, clear err_count, the first_err_* fields and
//     pass, then go to FEED.
//   - On start with num_vectors == 0: assert done and pass in the next cycle; stay in IDLE.
//   - start while busy is ignored.
// - State FEED:
//   - Each cycle, push valid=1 with the current stim and increment the issued count.
//   - After num_vectors pushes, go to DRAIN and push valid=0 from then on.
// - State DRAIN:
//   - Wait until all valid bits are 0 and the compared count equals num_vectors.
//   - Then: done=1 for 1 cycle, busy=0, pass = (err_count==0), return to IDLE.
// - Compare rules, applied each cycle the stage-LATENCY valid bit is 1:
//   - Increment the compared count.
//   - On mismatch, err_count += 1, holding at all-ones once reached.
//   - On the first mismatch of the run only, capture the index (compared count before increment),
//     exp and obs.
// - busy is 1 in FEED and DRAIN.
// - The first LATENCY cycles after start are never compared: their valid bits are 0. This masks the
//   unreset addsub register.
// - rst asserted mid-run: abort immediately to IDLE with the reset values; no done pulse.
// - Simultaneous compare and transition to DRAIN: both take effect in the same cycle.
// TESTING
// - Add: stim=0x0005_0003 (op=1) -> after 2 cycles exp=0x0000_0008; obs equal -> err_count 0.
// - Sub underflow: stim=0x0005_0002 (op=0) -> exp=0xFFFF_FFFD; a bench forcing obs=0x0000_FFFD gives
//   err_count=1, first_err_idx=0, exp 0xFFFF_FFFD, obs 0x0000_FFFD.
// - Carry: stim=0xFFFF_FFFF (op=1) -> exp=0x0001_FFFE; stim=0x0000_0000 (op=0) -> exp=0.
// - Run of 100 random vectors against a real addsub_top -> done pulses exactly 102 cycles after the
//   first FEED cycle; pass=1, err_count=0.
// - Corrupt vectors 7 and 9 of a 20-vector run -> err_count=2, first_err_idx=7, pass=0.
// - num_vectors=0 -> done and pass the next cycle. rst pulsed at vector 5 of 50 -> outputs return to
//   0 with no done pulse; a following start runs clean.

Source files
------------

// File: rtl/addsub_result_checker_if.sv
// Stimulus/observation and status bundle between the add/sub result checker and its driver.
interface addsub_result_checker_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_vectors;
  logic [WIDTH-1:0] stim;
  logic [WIDTH-1:0] obs;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] first_err_idx;
  logic [WIDTH-1:0] first_err_exp;
  logic [WIDTH-1:0] first_err_obs;

  modport master (
    output start, num_vectors, stim, obs,
    input  busy, done, pass, err_count, first_err_idx, first_err_exp, first_err_obs
  );

  modport slave (
    input  start, num_vectors, stim, obs,
    output busy, done, pass, err_count, first_err_idx, first_err_exp, first_err_obs
  );
endinterface

// File: rtl/addsub_result_checker.sv
// Recomputes the add/sub result from the stimulus word in a delay-matched pipeline,
// compares it against the datapath output and records the run's mismatch statistics.
module addsub_result_checker #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  addsub_result_checker_if.slave  bus
);
  localparam int HALF = WIDTH / 2;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // a = low half, b = high half, op = bit 0 (shared with a); zero-extended modular arithmetic
  function automatic logic [WIDTH-1:0] calc_exp(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    a = {{(WIDTH-HALF){1'b0}}, s[HALF-1:0]};
    b = {{(WIDTH-HALF){1'b0}}, s[WIDTH-1:HALF]};
    return s[0] ? (a + b) : (a - b);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] nvec_q, nvec_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] cmp_cnt_q, cmp_cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] fidx_q, fidx_d;
  logic [WIDTH-1:0] fexp_q, fexp_d;
  logic [WIDTH-1:0] fobs_q, fobs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]   exp_pipe_q [LATENCY];
  logic [WIDTH-1:0]   exp_pipe_d [LATENCY];
  logic               cmp_en_s;
  logic               mism_s;

  // Delay-matched expected-value pipeline and compare strobe
  always_comb begin
    exp_pipe_d[0] = calc_exp(bus.stim);
    vld_d[0]      = (state_q == FEED);
    for (int i = 1; i < LATENCY; i++) begin
      exp_pipe_d[i] = exp_pipe_q[i-1];
      vld_d[i]      = vld_q[i-1];
    end
    cmp_en_s = vld_q[LATENCY-1];
    mism_s   = cmp_en_s && (bus.obs != exp_pipe_q[LATENCY-1]);
  end

  // Run control FSM, compare bookkeeping and status next-state
  always_comb begin
    state_d   = state_q;
    nvec_d    = nvec_q;
    issued_d  = issued_q;
    cmp_cnt_d = cmp_en_s ? (cmp_cnt_q + CNT_ONE) : cmp_cnt_q;
    err_d     = (mism_s && (err_q != {CNT_W{1'b1}})) ? (err_q + CNT_ONE) : err_q;
    fidx_d    = fidx_q;
    fexp_d    = fexp_q;
    fobs_d    = fobs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;

    if (mism_s && (err_q == {CNT_W{1'b0}})) begin
      fidx_d = cmp_cnt_q;
      fexp_d = exp_pipe_q[LATENCY-1];
      fobs_d = bus.obs;
    end else begin
      fidx_d = fidx_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          err_d  = {CNT_W{1'b0}};
          fidx_d = {CNT_W{1'b0}};
          fexp_d = {WIDTH{1'b0}};
          fobs_d = {WIDTH{1'b0}};
          if (bus.num_vectors != {CNT_W{1'b0}}) begin
            nvec_d    = bus.num_vectors;
            issued_d  = {CNT_W{1'b0}};
            cmp_cnt_d = {CNT_W{1'b0}};
            pass_d    = 1'b0;
            busy_d    = 1'b1;
            state_d   = FEED;
          end else begin
            done_d = 1'b1;
            pass_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FEED: begin
        issued_d = issued_q + CNT_ONE;
        if (issued_d == nvec_q) begin
          state_d = DRAIN;
        end else begin
          state_d = FEED;
        end
      end
      DRAIN: begin
        // Looking at next-cycle values lets done land the cycle after the last compare
        if ((vld_d == {LATENCY{1'b0}}) && (cmp_cnt_d == nvec_q)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == {CNT_W{1'b0}});
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, pipeline and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      nvec_q    <= {CNT_W{1'b0}};
      issued_q  <= {CNT_W{1'b0}};
      cmp_cnt_q <= {CNT_W{1'b0}};
      err_q     <= {CNT_W{1'b0}};
      fidx_q    <= {CNT_W{1'b0}};
      fexp_q    <= {WIDTH{1'b0}};
      fobs_q    <= {WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      vld_q     <= {LATENCY{1'b0}};
      for (int i = 0; i < LATENCY; i++) begin
        exp_pipe_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      nvec_q    <= nvec_d;
      issued_q  <= issued_d;
      cmp_cnt_q <= cmp_cnt_d;
      err_q     <= err_d;
      fidx_q    <= fidx_d;
      fexp_q    <= fexp_d;
      fobs_q    <= fobs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      vld_q     <= vld_d;
      for (int i = 0; i < LATENCY; i++) begin
        exp_pipe_q[i] <= exp_pipe_d[i];
      end
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = fidx_q;
  assign bus.first_err_exp = fexp_q;
  assign bus.first_err_obs = fobs_q;
endmodule

// File: tb/tb_addsub_result_checker.sv
// Self-checking bench: a two-stage add/sub datapath model with per-vector corruption feeds the
// checker; expected run summaries are queued at start and compared when done pulses.
module tb_addsub_result_checker;
  logic clk;
  logic rst;
  logic [31:0] xin;
  logic [31:0] m1_q;
  logic [31:0] m2_q;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [15:0] errs;
    logic [15:0] idx;
    logic [31:0] fexp;
    logic [31:0] fobs;
    logic        pass;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] stim_v[$];
  logic [31:0] xor_v[$];

  addsub_result_checker_if #(.WIDTH(32), .CNT_W(16)) bus ();

  addsub_result_checker #(.WIDTH(32), .LATENCY(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_exp(input logic [31:0] s);
    logic [31:0] a;
    logic [31:0] b;
    a = {16'h0000, s[15:0]};
    b = {16'h0000, s[31:16]};
    if (s[0]) return a + b;
    return a - b;
  endfunction

  // Datapath model: addsub register then output register; xin corrupts a chosen vector
  always_ff @(posedge clk) begin
    m1_q <= ref_exp(bus.stim) ^ xin;
    m2_q <= m1_q;
  end
  assign bus.obs = m2_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    check_eq({tag, "_pass"}, {31'd0, bus.pass}, 32'd0);
    check_eq({tag, "_err"}, {16'd0, bus.err_count}, 32'd0);
    check_eq({tag, "_fidx"}, {16'd0, bus.first_err_idx}, 32'd0);
    check_eq({tag, "_fexp"}, bus.first_err_exp, 32'd0);
    check_eq({tag, "_fobs"}, bus.first_err_obs, 32'd0);
  endtask

  // Runs n vectors from stim_v/xor_v; abort_at >= 0 pulses rst at that vector instead of finishing
  task automatic run_vectors(input int n, input int abort_at, input bit glitch,
                             input bit ovr, input logic [31:0] ovr_exp);
    exp_t e;
    int   k;
    bit   seen;
    e.errs = 16'd0; e.idx = 16'd0; e.fexp = 32'd0; e.fobs = 32'd0;
    for (int i = 0; i < n; i++) begin
      if (xor_v[i] != 32'd0) begin
        if (e.errs == 16'd0) begin
          e.idx  = 16'(i);
          e.fexp = ovr ? ovr_exp : ref_exp(stim_v[i]);
          e.fobs = e.fexp ^ xor_v[i];
        end
        e.errs = e.errs + 16'd1;
      end
    end
    e.pass = (e.errs == 16'd0);
    if (abort_at < 0) sb.push_back(e);

    @(negedge clk);
    bus.start       = 1'b1;
    bus.num_vectors = 16'(n);
    seen = 1'b0;
    for (k = 0; k < n + 20; k++) begin
      @(negedge clk);
      bus.start       = glitch && (k == 3);
      bus.num_vectors = (glitch && (k == 3)) ? 16'd3 : 16'(n);
      if (k == 0) check_eq("busy_run", {31'd0, bus.busy}, 32'd1);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (k == abort_at) break;
      if (k < n) begin
        bus.stim = stim_v[k];
        xin      = xor_v[k];
      end else begin
        bus.stim = $urandom;
        xin      = 32'd0;
      end
    end

    if (abort_at >= 0) begin
      check_eq("abort_no_done", {31'd0, seen}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_zero("abort");
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        if (bus.done) check_eq("abort_done_pulse", {31'd0, bus.done}, 32'd0);
      end
      check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
    end else begin
      check_eq("done_seen", {31'd0, seen}, 32'd1);
      e = sb.pop_front();
      if (seen) begin
        check_eq("done_lat", 32'(k), 32'(n + 2));
        check_eq("err_count", {16'd0, bus.err_count}, {16'd0, e.errs});
        check_eq("first_idx", {16'd0, bus.first_err_idx}, {16'd0, e.idx});
        check_eq("first_exp", bus.first_err_exp, e.fexp);
        check_eq("first_obs", bus.first_err_obs, e.fobs);
        check_eq("pass", {31'd0, bus.pass}, {31'd0, e.pass});
        check_eq("busy_end", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check_eq("done_1cyc", {31'd0, bus.done}, 32'd0);
        check_eq("pass_hold", {31'd0, bus.pass}, {31'd0, e.pass});
      end
    end
  endtask

  task automatic load_random(input int n);
    stim_v.delete();
    xor_v.delete();
    for (int i = 0; i < n; i++) begin
      stim_v.push_back($urandom);
      xor_v.push_back(32'd0);
    end
  endtask

  task automatic load_one(input logic [31:0] s, input logic [31:0] x);
    stim_v.delete();
    xor_v.delete();
    stim_v.push_back(s);
    xor_v.push_back(x);
  endtask

  logic [31:0] dir_stim [4];
  logic [31:0] dir_exp  [4];
  logic [31:0] dir_mask [4];

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    xin             = 32'd0;
    bus.start       = 1'b0;
    bus.num_vectors = 16'd0;
    bus.stim        = 32'd0;
    dir_stim[0] = 32'h0005_0003; dir_exp[0] = 32'h0000_0008; dir_mask[0] = 32'h0000_0100;
    dir_stim[1] = 32'h0005_0002; dir_exp[1] = 32'hFFFF_FFFD; dir_mask[1] = 32'hFFFF_0000;
    dir_stim[2] = 32'hFFFF_FFFF; dir_exp[2] = 32'h0001_FFFE; dir_mask[2] = 32'h0000_0001;
    dir_stim[3] = 32'h0000_0000; dir_exp[3] = 32'h0000_0000; dir_mask[3] = 32'h8000_0000;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("post_reset");

    // Directed vectors: clean run, then a corrupted run exposing the checker's expected value
    for (int d = 0; d < 4; d++) begin
      load_one(dir_stim[d], 32'd0);
      run_vectors(1, -1, 1'b0, 1'b1, dir_exp[d]);
      load_one(dir_stim[d], dir_mask[d]);
      run_vectors(1, -1, 1'b0, 1'b1, dir_exp[d]);
    end

    load_random(100);
    run_vectors(100, -1, 1'b0, 1'b0, 32'd0);

    load_random(20);
    xor_v[7] = 32'h0000_0010;
    xor_v[9] = 32'h0100_0000;
    run_vectors(20, -1, 1'b1, 1'b0, 32'd0);

    @(negedge clk);
    bus.start       = 1'b1;
    bus.num_vectors = 16'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("zero_done", {31'd0, bus.done}, 32'd1);
    check_eq("zero_pass", {31'd0, bus.pass}, 32'd1);
    check_eq("zero_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    check_eq("zero_done_1cyc", {31'd0, bus.done}, 32'd0);
    check_eq("zero_pass_hold", {31'd0, bus.pass}, 32'd1);

    load_random(50);
    xor_v[2] = 32'h0000_0004;
    run_vectors(50, 5, 1'b0, 1'b0, 32'd0);

    load_random(30);
    run_vectors(30, -1, 1'b0, 1'b0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
